// File: rtl/dmac_seq_ctrl_if.sv
// Job/result handshake and MAC control bundle for the bitstream MAC sequencer.
// The master side is the sequencer; the slave side is the job source, MAC and result sink.
interface dmac_seq_ctrl_if #(
    parameter int LEN_W = 8
);
    logic                    start_valid;
    logic                    start_ready;
    logic [3:0]              len_log2;
    logic                    loadA;
    logic                    loadB;
    logic                    mac_en;
    logic                    iC;
    logic                    res_valid;
    logic                    res_ready;
    logic [LEN_W:0]          res_ones;
    logic signed [LEN_W+1:0] res_bi;
    logic                    busy;

    modport master (
        input  start_valid, len_log2, iC, res_ready,
        output start_ready, loadA, loadB, mac_en, res_valid, res_ones, res_bi, busy
    );

    modport slave (
        output start_valid, len_log2, iC, res_ready,
        input  start_ready, loadA, loadB, mac_en, res_valid, res_ones, res_bi, busy
    );
endinterface

// File: rtl/dmac_seq_ctrl.sv
// Sequencer for a stochastic bitstream MAC: loads operands, runs the stream for
// PIPE+L cycles, counts ones in the last L output bits and presents the bipolar result.
module dmac_seq_ctrl #(
    parameter int LEN_W = 8,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    dmac_seq_ctrl_if.master  bus
);
    localparam int          L_MAX   = 1 << LEN_W;
    localparam int          CNT_W   = $clog2(PIPE + L_MAX + 1);
    localparam logic [3:0]  LEN_CAP = 4'(LEN_W);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                  state_reg;
    logic                    run_en_reg;
    logic [3:0]              len_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [LEN_W:0]          ones_reg;
    logic signed [LEN_W+1:0] bi_reg;
    logic                    start_ready_reg;
    logic                    busy_reg;
    logic                    load_reg;
    logic                    mac_en_reg;
    logic                    res_valid_reg;

    logic [3:0]              len_clamped;
    logic [LEN_W:0]          l_val;
    logic [CNT_W-1:0]        last_cnt;
    logic                    sample;
    logic [LEN_W:0]          ones_next;
    logic signed [LEN_W+2:0] bi_wide;
    logic                    accept;

    assign len_clamped = (bus.len_log2 > LEN_CAP) ? LEN_CAP : bus.len_log2;

    // L = 2^len_reg as a one-hot word; len_reg never exceeds LEN_W after clamping.
    generate
        for (genvar gi = 0; gi <= LEN_W; gi++) begin : g_len_decode
            assign l_val[gi] = (len_reg == 4'(gi));
        end
    endgenerate

    assign last_cnt  = CNT_W'(PIPE) + CNT_W'(l_val) - CNT_W'(1);
    assign sample    = (state_reg == RUN) && (cnt_reg >= CNT_W'(PIPE));
    assign ones_next = ones_reg + {{LEN_W{1'b0}}, (sample & bus.iC)};
    assign bi_wide   = $signed({1'b0, ones_next, 1'b0}) - $signed({2'b00, l_val});

    // run_en_reg holds off job acceptance on the first edge after reset release.
    assign accept = bus.start_valid && start_ready_reg && run_en_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            run_en_reg      <= 1'b0;
            len_reg         <= '0;
            cnt_reg         <= '0;
            ones_reg        <= '0;
            bi_reg          <= '0;
            start_ready_reg <= 1'b1;
            busy_reg        <= 1'b0;
            load_reg        <= 1'b0;
            mac_en_reg      <= 1'b0;
            res_valid_reg   <= 1'b0;
        end else begin
            run_en_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg       <= LOAD;
                        len_reg         <= len_clamped;
                        cnt_reg         <= '0;
                        ones_reg        <= '0;
                        bi_reg          <= '0;
                        start_ready_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                        load_reg        <= 1'b1;
                    end
                end
                LOAD: begin
                    state_reg  <= RUN;
                    cnt_reg    <= '0;
                    load_reg   <= 1'b0;
                    mac_en_reg <= 1'b1;
                end
                RUN: begin
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    ones_reg <= ones_next;
                    if (cnt_reg == last_cnt) begin
                        state_reg     <= DONE;
                        mac_en_reg    <= 1'b0;
                        res_valid_reg <= 1'b1;
                        bi_reg        <= bi_wide[LEN_W+1:0];
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_reg       <= IDLE;
                        res_valid_reg   <= 1'b0;
                        busy_reg        <= 1'b0;
                        start_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_reg;
    assign bus.busy        = busy_reg;
    assign bus.loadA       = load_reg;
    assign bus.loadB       = load_reg;
    assign bus.mac_en      = mac_en_reg;
    assign bus.res_valid   = res_valid_reg;
    assign bus.res_ones    = ones_reg;
    assign bus.res_bi      = bi_reg;
endmodule

// File: tb/tb_dmac_seq_ctrl.sv
// Directed bench for dmac_seq_ctrl: a table of jobs with hand-computed results,
// plus sequences for mid-run reset, release-edge handshake and back-to-back jobs.
module tb_dmac_seq_ctrl;
    localparam int LEN_W = 8;
    localparam int PIPE  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dmac_seq_ctrl_if #(.LEN_W(LEN_W)) bus ();

    dmac_seq_ctrl #(.LEN_W(LEN_W), .PIPE(PIPE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // mode: 0 all zeros, 1 all ones, 2 alternating 1,0, 3 one every third bit
    typedef struct {
        int len;
        int mode;
        int hold;
        int ones;
        int bi;
        int macen;
        int lat;
    } vec_t;

    vec_t tbl[10];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ic_bit(input int mode, input int k);
        int j;
        if (k < PIPE) return 1'b1;
        j = k - PIPE;
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (j % 2) == 0;
            default: return (j % 3) == 0;
        endcase
    endfunction

    task automatic run_job(input int idx, input vec_t v);
        int  cyc;
        int  k;
        int  la;
        int  lb;
        bit  got;
        bit  rdy;
        cyc = 0; k = 0; la = 0; lb = 0; got = 0; rdy = 0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus.start_ready) begin
                rdy = 1;
                break;
            end
        end
        chk($sformatf("job%0d_start_ready", idx), int'(rdy), 1);
        if (!rdy) return;
        bus.start_valid = 1'b1;
        bus.len_log2    = 4'(v.len);
        @(posedge clk);
        #1 bus.start_valid = 1'b0;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (bus.loadA) la++;
            if (bus.loadB) lb++;
            if (bus.mac_en) begin
                bus.iC = ic_bit(v.mode, k);
                k++;
            end else begin
                bus.iC = 1'b1;
            end
            if (bus.res_valid) begin
                got = 1;
                break;
            end
        end
        chk($sformatf("job%0d_res_valid_seen", idx), int'(got), 1);
        if (!got) return;
        chk($sformatf("job%0d_latency", idx), cyc, v.lat);
        chk($sformatf("job%0d_mac_en_cycles", idx), k, v.macen);
        chk($sformatf("job%0d_loadA_pulses", idx), la, 1);
        chk($sformatf("job%0d_loadB_pulses", idx), lb, 1);
        chk($sformatf("job%0d_res_ones", idx), int'(bus.res_ones), v.ones);
        chk($sformatf("job%0d_res_bi", idx), int'(bus.res_bi), v.bi);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk($sformatf("job%0d_hold%0d_valid", idx, h), int'(bus.res_valid), 1);
            chk($sformatf("job%0d_hold%0d_ones", idx, h), int'(bus.res_ones), v.ones);
            chk($sformatf("job%0d_hold%0d_bi", idx, h), int'(bus.res_bi), v.bi);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk($sformatf("job%0d_idle_valid", idx), int'(bus.res_valid), 0);
        chk($sformatf("job%0d_idle_busy", idx), int'(bus.busy), 0);
        chk($sformatf("job%0d_idle_ready", idx), int'(bus.start_ready), 1);
        chk($sformatf("job%0d_idle_ones_kept", idx), int'(bus.res_ones), v.ones);
        $display("job %0d: len_log2=%0d mode=%0d ones=%0d bi=%0d latency=%0d", idx, v.len,
                 v.mode, int'(bus.res_ones), int'(bus.res_bi), cyc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, int'(bus.start_ready), 1);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_loadA"}, int'(bus.loadA), 0);
        chk({tag, "_loadB"}, int'(bus.loadB), 0);
        chk({tag, "_mac_en"}, int'(bus.mac_en), 0);
        chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
        chk({tag, "_res_ones"}, int'(bus.res_ones), 0);
        chk({tag, "_res_bi"}, int'(bus.res_bi), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n_run;
        int   n_loads;
        int   n_busy_low;
        int   last_load;
        int   gap_bad;
        int   vr_seen;
        bit   idle_ok;

        //          len mode hold ones   bi macen lat
        tbl[0] = '{ 4,  1,   0,   16,   16,  17,  19};
        tbl[1] = '{ 8,  2,   0,  128,    0, 257, 259};
        tbl[2] = '{ 3,  0,  10,    0,   -8,   9,  11};
        tbl[3] = '{12,  1,   2,  256,  256, 257, 259};
        tbl[4] = '{ 0,  1,   0,    1,    1,   2,   4};
        tbl[5] = '{ 0,  0,   1,    0,   -1,   2,   4};
        tbl[6] = '{ 2,  2,   0,    2,    0,   5,   7};
        tbl[7] = '{ 5,  3,   3,   11,  -10,  33,  35};
        tbl[8] = '{15,  0,   0,    0, -256, 257, 259};
        tbl[9] = '{ 3,  3,   0,    3,   -2,   9,  11};

        bus.start_valid = 1'b0;
        bus.len_log2    = 4'd0;
        bus.iC          = 1'b1;
        bus.res_ready   = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("cold_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_job(i, tbl[i]);
        end

        // Reset in the fifth RUN cycle: everything returns to reset values at once.
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.len_log2    = 4'd4;
        @(posedge clk);
        #1 bus.start_valid = 1'b0;
        n_run = 0;
        for (int c = 0; c < 40 && n_run < 5; c++) begin
            @(negedge clk);
            if (bus.mac_en) n_run++;
        end
        chk("midrun_reached_run5", n_run, 5);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrun_reset");
        vr_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.res_valid) vr_seen++;
        end
        chk("midrun_no_result", vr_seen, 0);

        // A request already pending at release must not be taken on the release edge.
        bus.start_valid = 1'b1;
        bus.len_log2    = 4'd2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_edge_loadA", int'(bus.loadA), 0);
        chk("release_edge_busy", int'(bus.busy), 0);
        bus.start_valid = 1'b0;
        v = '{2, 1, 0, 4, 4, 5, 7};
        run_job(10, v);

        // Continuous start_valid with res_ready high: one job every PIPE+L+3 cycles.
        @(negedge clk);
        bus.len_log2    = 4'd0;
        bus.res_ready   = 1'b1;
        bus.iC          = 1'b1;
        bus.start_valid = 1'b1;
        n_loads = 0; n_busy_low = 0; last_load = -1; gap_bad = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.loadA) begin
                if (last_load >= 0 && (c - last_load) != PIPE + 4) gap_bad++;
                last_load = c;
                n_loads++;
            end
            if (n_loads > 0 && !bus.busy) n_busy_low++;
        end
        bus.start_valid = 1'b0;
        chk("b2b_load_count", n_loads, 4);
        chk("b2b_busy_low_cycles", n_busy_low, 3);
        chk("b2b_bad_gaps", gap_bad, 0);
        idle_ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus.busy) begin
                idle_ok = 1;
                break;
            end
        end
        bus.res_ready = 1'b0;
        chk("b2b_returns_idle", int'(idle_ok), 1);
        chk("b2b_last_ones", int'(bus.res_ones), 1);
        chk("b2b_last_bi", int'(bus.res_bi), 1);
        $display("back-to-back: loads=%0d busy_low=%0d", n_loads, n_busy_low);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
